vfifo_sc_fwft: RTL
==================

Name: vfifo_sc_fwft

Overview:
- Single-clock, first-word-fall-through FIFO controller.
- Owns the write and read pointers around one simple-dual-port RAM: RAM write port A, registered-address read port B.
- Presents a push interface upstream and a valid/ready pop interface downstream.
- rd_data comes from an output register; RAM read timing does not reach the consumer.

Parameters:
- DATA_WIDTH, 8, width of each stored word.
- ADDR_WIDTH, 4, RAM address width; DEPTH = 2**ADDR_WIDTH RAM words.
- AF_LEVEL, DEPTH-2, almost_full threshold (only with the optional feature).
- AE_LEVEL, 2, almost_empty threshold (only with the optional feature).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- wr_en  in  1  push request.
- wr_data  in  DATA_WIDTH  push data.
- full  out  1  no RAM slot free; a push is ignored.
- rd_valid  out  1  rd_data holds the head word.
- rd_ready  in  1  consumer accepts the head word.
- rd_data  out  DATA_WIDTH  head word (registered).
- count  out  ADDR_WIDTH+1  words held (RAM plus output register), 0..DEPTH+1.
- almost_full  out  1  optional; count >= AF_LEVEL.
- almost_empty  out  1  optional; count <= AE_LEVEL.

Behaviour:
- Reset (rst_n=0 at an edge):
  - wr_ptr, rd_ptr and free_ptr cleared; q_valid and rd_valid cleared; count 0.
  - full 0, almost_empty 1, almost_full 0; rd_data 0.
  - RAM contents are not cleared.
  - Reset mid-operation discards every word, including any read in flight.
- Pointers are ADDR_WIDTH+1 bits with an extra wrap bit:
  - wr_ptr: next RAM address to write.
  - rd_ptr: next RAM address to issue a read to.
  - free_ptr: oldest RAM address not yet moved into the output register.
- Push:
  - Accepted when wr_en && !full; RAM[wr_ptr] <= wr_data and wr_ptr++ at that edge.
  - wr_en while full: no RAM write, no state change.
- full = (wr_ptr - free_ptr) == DEPTH. A slot is freed only when its word lands in the output register, so an issued but unlanded word is never overwritten.
- Read issue:
  - stall = q_valid && rd_valid && !rd_ready.
  - Issue when (rd_ptr != wr_ptr) && !stall: RAM address = rd_ptr[ADDR_WIDTH-1:0], rd_ptr++, q_valid <= 1.
  - Not issuing and not stalled: q_valid <= 0.
  - While stalled: re-present address rd_ptr-1 to the RAM so its data stays valid; hold q_valid and rd_ptr.
- Land:
  - Occurs when q_valid && (!rd_valid || rd_ready): rd_data <= RAM output, rd_valid <= 1, free_ptr++.
  - Pop without land: rd_valid <= 0.
- Pop: rd_valid && rd_ready at an edge. rd_ready while !rd_valid is ignored.
- Latency:
  - Word pushed at edge k into an empty FIFO shows rd_valid=1 after edge k+2.
  - Sustained throughput is 1 word/clk with rd_ready held high.
- count = (wr_ptr - free_ptr) + rd_valid.
- Simultaneous push and pop, and push while a read is in flight, are both legal and lossless.
- The RAM never sees a read and a write to the same address in the same cycle: issued addresses differ from wr_ptr unless the FIFO is full, and full blocks writes.
- Wrap-around: pointers wrap modulo 2*DEPTH; the RAM address is the low ADDR_WIDTH bits.

Optional Feature:
- Macro: VFIFO_SC_FWFT_ALMOST_EN.
- Defined: almost_full and almost_empty are registered, updated from next-state count, reset to 0 and 1 respectively.
- Undefined: both ports and AF_LEVEL/AE_LEVEL logic are absent; the port list omits them.

Decomposition:
- Shared defines/package holds:
  - DATA_WIDTH and ADDR_WIDTH defaults.
  - The derived DEPTH and pointer-width constants.
  - The VFIFO_SC_FWFT_ALMOST_EN switch.
- One sub-module: the existing single-clock simple-dual-port RAM, vfifo_dual_port_ram_sc_sw, instantiated unmodified.
  - Controller drives d_a/adr_a/we_a and adr_b; takes q_b.
- All pointer, stall and landing logic stays in vfifo_sc_fwft.

Test Plan:
- Reset then idle 5 clks -> rd_valid=0, full=0, count=0, almost_empty=1.
- Push 0xA5 at edge 1 with rd_ready=0 -> rd_valid=1 and rd_data=0xA5 after edge 3; count=1 from edge 1 onward.
- Push 17 words 0x00..0x10 with rd_ready=0 (DEPTH=16) -> 16 in RAM plus 1 in the output register; count=17; push 0xFF while full is ignored; draining yields 0x00..0x10 in order.
- wr_en=1 and rd_ready=1 continuously for 40 clks with incrementing data -> one pop per clk once steady; sequence in order with no gaps or duplicates; count stable; pointer wrap crossed twice.
- Toggle rd_ready 1,0,0,1 while q_valid=1 -> no word lost or duplicated; stalled word delivered next.
- Assert rd_n... (rst_n)=0 mid-stream with 5 words held -> next clk count=0, rd_valid=0, full=0; the next push 0x3C emerges first.

Source files
------------

// File: rtl/vfifo_sc_fwft_pkg.sv
// vfifo_sc_fwft shared defaults and derived-size helpers.
// Optional almost flags: define VFIFO_SC_FWFT_ALMOST_EN.
package vfifo_sc_fwft_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int ADDR_WIDTH_DEF = 4;

  function automatic int depth_of(input int aw);
    return 1 << aw;
  endfunction

  // Pointers carry one extra wrap bit.
  function automatic int ptr_width(input int aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/vfifo_dual_port_ram_sc_sw.sv
// Single-clock simple-dual-port RAM.
// Port A writes; port B reads through a registered address.
module vfifo_dual_port_ram_sc_sw #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic [DATA_WIDTH-1:0] d_a,
  input  logic [ADDR_WIDTH-1:0] adr_a,
  input  logic                  we_a,
  input  logic [ADDR_WIDTH-1:0] adr_b,
  output logic [DATA_WIDTH-1:0] q_b
);

  logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];
  logic [ADDR_WIDTH-1:0] adr_b_q;

  // Write port A and capture the read address for port B.
  always_ff @(posedge clk) begin
    if (we_a) mem[adr_a] <= d_a;
    adr_b_q <= adr_b;
  end

  assign q_b = mem[adr_b_q];

endmodule

// File: rtl/vfifo_sc_fwft.sv
// Single-clock FWFT FIFO controller around a SDP RAM.
// Optional almost flags: define VFIFO_SC_FWFT_ALMOST_EN.
module vfifo_sc_fwft
  import vfifo_sc_fwft_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
`ifdef VFIFO_SC_FWFT_ALMOST_EN
  ,
  parameter int AF_LEVEL = depth_of(ADDR_WIDTH) - 2,
  parameter int AE_LEVEL = 2
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH:0]   count
`ifdef VFIFO_SC_FWFT_ALMOST_EN
  ,
  output logic                  almost_full,
  output logic                  almost_empty
`endif
);

  localparam int PW = ptr_width(ADDR_WIDTH);
  localparam logic [PW-1:0] DEPTH_P =
    PW'(depth_of(ADDR_WIDTH));
  localparam logic [PW-1:0] ONE = PW'(1);
  localparam logic [ADDR_WIDTH-1:0] A_ONE =
    ADDR_WIDTH'(1);

  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         free_ptr;
  logic [PW-1:0]         used;
  logic                  q_valid;
  logic                  push;
  logic                  pop;
  logic                  stall;
  logic                  issue;
  logic                  land;
  logic [ADDR_WIDTH-1:0] adr_b;
  logic [DATA_WIDTH-1:0] q_b;

  // Slots stay owned until their word reaches rd_data.
  assign used  = wr_ptr - free_ptr;
  assign full  = (used == DEPTH_P);
  assign push  = wr_en && !full;
  assign pop   = rd_valid && rd_ready;
  assign stall = q_valid && rd_valid && !rd_ready;
  assign issue = (rd_ptr != wr_ptr) && !stall;
  assign land  = q_valid && !stall;
  assign count = used + {{(PW-1){1'b0}}, rd_valid};

  // A stalled read keeps its address so q_b holds.
  assign adr_b = stall
    ? rd_ptr[ADDR_WIDTH-1:0] - A_ONE
    : rd_ptr[ADDR_WIDTH-1:0];

  vfifo_dual_port_ram_sc_sw #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .d_a   (wr_data),
    .adr_a (wr_ptr[ADDR_WIDTH-1:0]),
    .we_a  (push && rst_n),
    .adr_b (adr_b),
    .q_b   (q_b)
  );

  // Pointer, in-flight read and output register state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      free_ptr <= '0;
      q_valid  <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ONE;
      if (issue) rd_ptr <= rd_ptr + ONE;
      if (!stall) q_valid <= issue;
      if (land) begin
        rd_data  <= q_b;
        rd_valid <= 1'b1;
        free_ptr <= free_ptr + ONE;
      end else if (pop) begin
        rd_valid <= 1'b0;
      end
    end
  end

`ifdef VFIFO_SC_FWFT_ALMOST_EN
  localparam logic [PW-1:0] AF_P = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE_P = PW'(AE_LEVEL);

  logic [PW-1:0] wr_nxt;
  logic [PW-1:0] free_nxt;
  logic          rv_nxt;
  logic [PW-1:0] cnt_nxt;

  assign wr_nxt   = push ? wr_ptr + ONE : wr_ptr;
  assign free_nxt = land ? free_ptr + ONE : free_ptr;
  assign rv_nxt   = land || (rd_valid && !pop);
  assign cnt_nxt  = (wr_nxt - free_nxt)
                  + {{(PW-1){1'b0}}, rv_nxt};

  // Flags track the count the next edge will hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      almost_full  <= (cnt_nxt >= AF_P);
      almost_empty <= (cnt_nxt <= AE_P);
    end
  end
`endif

endmodule
